// File: rtl/dm_write_buffer_if.sv
// -----------------------------------------------------------------------------
// dm_write_buffer_if
//
// Bus bundle between the CPU data-memory port, the posted write buffer and the
// DM SRAM. The buffer sits on the slave modport. The CPU/SRAM side (or a
// testbench) uses the master modport.
//
// CPU side : cpu_req, cpu_web, cpu_bweb, cpu_a, cpu_din, flush  (to buffer)
//            cpu_dout, cpu_rvalid, cpu_stall                    (from buffer)
// SRAM side: mem_ceb, mem_web, mem_bweb, mem_a, mem_din         (from buffer)
//            mem_dout, mem_ready                                (to buffer)
// -----------------------------------------------------------------------------
interface dm_write_buffer_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_web;
    logic [DW-1:0] cpu_bweb;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_rvalid;
    logic          cpu_stall;
    logic          flush;
    logic          mem_ceb;
    logic          mem_web;
    logic [DW-1:0] mem_bweb;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;

    modport slave (
        input  cpu_req, cpu_web, cpu_bweb, cpu_a, cpu_din, flush, mem_dout, mem_ready,
        output cpu_dout, cpu_rvalid, cpu_stall, mem_ceb, mem_web, mem_bweb, mem_a, mem_din
    );

    modport master (
        output cpu_req, cpu_web, cpu_bweb, cpu_a, cpu_din, flush, mem_dout, mem_ready,
        input  cpu_dout, cpu_rvalid, cpu_stall, mem_ceb, mem_web, mem_bweb, mem_a, mem_din
    );
endinterface

// File: rtl/dm_write_buffer.sv
// -----------------------------------------------------------------------------
// dm_write_buffer
//
// Posted store buffer between the CPU data-memory port and the DM SRAM.
// Stores retire into a DEPTH-entry FIFO in one cycle and drain to the SRAM
// when the port is otherwise idle. Loads go straight to the SRAM. Any buffered
// bytes for the same word are merged over the returned SRAM data, with the
// youngest store winning per bit.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - dm_write_buffer_if.slave (CPU request/response, flush, SRAM port)
//
// Parameters: DEPTH (power of two, >=2), AW (word address width), DW (data width)
//
// Optional build macro: DM_WB_COALESCE_EN
//   When defined, a store to the same word as the youngest buffered entry is
//   merged into that entry instead of allocating a new one. This also applies
//   when the FIFO is full. The merge is not done if that entry is draining
//   this cycle.
// -----------------------------------------------------------------------------
module dm_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 14,
    parameter int DW    = 32
) (
    input logic              clk,
    input logic              rst,
    dm_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] wmask;   // 1 = bit written by the store
    } entry_t;

    // FIFO storage and pointers
    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_pending_q, flush_pending_d;

    // Load return path
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;
    logic [DW-1:0] fwd_mask_q, fwd_mask_d;

    // SRAM request fields hold their last driven value while idle
    logic          mem_web_q, mem_web_d;
    logic [DW-1:0] mem_bweb_q, mem_bweb_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_din_q, mem_din_d;

    // Arbitration results
    logic          is_load, is_store;
    logic          has_entry, full, flush_act, urgent;
    logic          drain_go, load_go, store_go, alloc, coalesce_hit;
    entry_t        head_ent;
    logic [PW-1:0] idx;
`ifdef DM_WB_COALESCE_EN
    logic [PW-1:0] young_idx;
`endif

    // -------------------------------------------------------------------------
    // Arbitration: one SRAM access per cycle, and only when mem_ready is high.
    // Nothing is issued while rst is high, so reset takes effect at once.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
        is_load   = bus.cpu_req && bus.cpu_web;
        is_store  = bus.cpu_req && !bus.cpu_web;
        has_entry = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        // A fence against an empty FIFO has nothing to wait for. It therefore
        // neither stalls nor blocks anything.
        flush_act = flush_pending_q || (bus.flush && has_entry);
        urgent    = has_entry && (full || flush_act);
        head_ent  = ent_q[head_q];

        drain_go = 1'b0;
        load_go  = 1'b0;
        if (!rst && bus.mem_ready) begin
            if (urgent) begin
                drain_go = 1'b1;
            end else if (is_load && !flush_act) begin
                load_go = 1'b1;
            end else if (has_entry) begin
                drain_go = 1'b1;
            end
        end

`ifdef DM_WB_COALESCE_EN
        young_idx = tail_q - PW'(1);
        // When only one entry exists, the youngest entry is the head. That
        // entry must not change while it is being written out.
        coalesce_hit = has_entry && (ent_q[young_idx].addr == bus.cpu_a)
                       && !(drain_go && (count_q == CW'(1)));
`else
        coalesce_hit = 1'b0;
`endif
        // Occupancy is the registered count. A slot freed by this cycle's
        // drain only becomes available next cycle.
        store_go = !rst && is_store && !flush_act && (!full || coalesce_hit);
        alloc    = store_go && !coalesce_hit;

        bus.cpu_stall = !rst && bus.cpu_req && !(load_go || store_go);
    end

    // -------------------------------------------------------------------------
    // FIFO update, flush tracking and store-to-load forwarding
    // -------------------------------------------------------------------------
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;

        if (drain_go) begin
            head_d = head_q + PW'(1);
        end
        if (alloc) begin
            ent_d[tail_q] = '{addr: bus.cpu_a, data: bus.cpu_din, wmask: ~bus.cpu_bweb};
            tail_d        = tail_q + PW'(1);
        end
`ifdef DM_WB_COALESCE_EN
        if (store_go && coalesce_hit) begin
            ent_d[young_idx].data  = (ent_q[young_idx].data & bus.cpu_bweb)
                                   | (bus.cpu_din & ~bus.cpu_bweb);
            ent_d[young_idx].wmask = ent_q[young_idx].wmask | ~bus.cpu_bweb;
        end
`endif
        count_d = count_q + CW'(alloc) - CW'(drain_go);

        flush_pending_d = (bus.flush || flush_pending_q) && (count_d != '0);

        // Walk the entries from oldest to youngest. A younger entry overwrites
        // an older one for every bit it wrote.
        idx        = '0;
        fwd_data_d = fwd_data_q;
        fwd_mask_d = fwd_mask_q;
        if (load_go) begin
            fwd_data_d = '0;
            fwd_mask_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (ent_q[idx].addr == bus.cpu_a)) begin
                    fwd_data_d = (fwd_data_d & ~ent_q[idx].wmask)
                               | (ent_q[idx].data & ent_q[idx].wmask);
                    fwd_mask_d = fwd_mask_d | ent_q[idx].wmask;
                end
            end
        end
        rvalid_d = load_go;
    end

    // -------------------------------------------------------------------------
    // SRAM request outputs, combinational from arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        mem_web_d  = mem_web_q;
        mem_bweb_d = mem_bweb_q;
        mem_a_d    = mem_a_q;
        mem_din_d  = mem_din_q;
        if (drain_go) begin
            mem_web_d  = 1'b0;
            mem_bweb_d = ~head_ent.wmask;
            mem_a_d    = head_ent.addr;
            mem_din_d  = head_ent.data;
        end else if (load_go) begin
            mem_web_d = 1'b1;
            mem_a_d   = bus.cpu_a;
        end

        bus.mem_ceb  = !(drain_go || load_go);
        bus.mem_web  = mem_web_d;
        bus.mem_bweb = mem_bweb_d;
        bus.mem_a    = mem_a_d;
        bus.mem_din  = mem_din_d;
    end

    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_dout   = rvalid_q ? ((fwd_data_q & fwd_mask_q) | (bus.mem_dout & ~fwd_mask_q))
                                     : '0;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            rvalid_q        <= 1'b0;
            fwd_data_q      <= '0;
            fwd_mask_q      <= '0;
            mem_web_q       <= 1'b1;
            mem_bweb_q      <= '1;
            mem_a_q         <= '0;
            mem_din_q       <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            rvalid_q        <= rvalid_d;
            fwd_data_q      <= fwd_data_d;
            fwd_mask_q      <= fwd_mask_d;
            mem_web_q       <= mem_web_d;
            mem_bweb_q      <= mem_bweb_d;
            mem_a_q         <= mem_a_d;
            mem_din_q       <= mem_din_d;
        end
    end

    // NOTE: the entry array has no reset. count_q qualifies every read, so stale contents are never used.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_dm_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_dm_write_buffer
//
// Directed testbench for dm_write_buffer (DEPTH=4, AW=14, DW=32).
// Inputs change 1 time unit after the rising edge. Outputs are checked at the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dm_write_buffer;
    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dm_write_buffer_if #(.AW(AW), .DW(DW)) bus ();

    dm_write_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.cpu_req  = 1'b0;
        bus.cpu_web  = 1'b1;
        bus.cpu_bweb = '1;
        bus.cpu_a    = '0;
        bus.cpu_din  = '0;
    endtask

    task automatic drive_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] bweb);
        bus.cpu_req  = 1'b1;
        bus.cpu_web  = 1'b0;
        bus.cpu_bweb = bweb;
        bus.cpu_a    = a;
        bus.cpu_din  = d;
    endtask

    task automatic drive_load(input logic [AW-1:0] a);
        bus.cpu_req  = 1'b1;
        bus.cpu_web  = 1'b1;
        bus.cpu_bweb = '1;
        bus.cpu_a    = a;
        bus.cpu_din  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_dout  = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL reset_mem_ceb: got %b want 1", bus.mem_ceb); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_cpu_stall: got %b want 0", bus.cpu_stall); end
        total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL reset_cpu_rvalid: got %b want 0", bus.cpu_rvalid); end
        total++; if (bus.cpu_dout !== 32'h0) begin bad++; $display("FAIL reset_cpu_dout: got %h want 0", bus.cpu_dout); end
        total++; if (bus.mem_web !== 1'b1) begin bad++; $display("FAIL reset_mem_web: got %b want 1", bus.mem_web); end
        total++; if (bus.mem_bweb !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_mem_bweb: got %h want ffffffff", bus.mem_bweb); end
        total++; if (bus.mem_a !== 14'h0) begin bad++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
        total++; if (bus.mem_din !== 32'h0) begin bad++; $display("FAIL reset_mem_din: got %h want 0", bus.mem_din); end
        tick();
    endtask

    task automatic test_store_drain();
        bus.mem_ready = 1'b1;
        drive_store(14'h010, 32'hDEAD_BEEF, 32'h0);
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL sd_stall: got %b want 0", bus.cpu_stall); end
        total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL sd_idle_ceb: got %b want 1", bus.mem_ceb); end
        tick();
        drive_idle();
        settle();
        total++; if (bus.mem_ceb !== 1'b0) begin bad++; $display("FAIL sd_ceb: got %b want 0", bus.mem_ceb); end
        total++; if (bus.mem_web !== 1'b0) begin bad++; $display("FAIL sd_web: got %b want 0", bus.mem_web); end
        total++; if (bus.mem_a !== 14'h010) begin bad++; $display("FAIL sd_a: got %h want 010", bus.mem_a); end
        total++; if (bus.mem_din !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sd_din: got %h want deadbeef", bus.mem_din); end
        total++; if (bus.mem_bweb !== 32'h0) begin bad++; $display("FAIL sd_bweb: got %h want 0", bus.mem_bweb); end
        tick();
        settle();
        total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL sd_empty_ceb: got %b want 1", bus.mem_ceb); end
        total++; if (bus.mem_a !== 14'h010) begin bad++; $display("FAIL sd_hold_a: got %h want 010", bus.mem_a); end
        tick();
    endtask

    task automatic test_full();
        bus.mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_store(14'(k), 32'(k) * 32'h0101_0101, 32'h0);
            settle();
            total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL full_fill_stall[%0d]: got %b want 0", k, bus.cpu_stall); end
            tick();
        end
        drive_store(14'h005, 32'h0505_0505, 32'h0);
        settle();
        total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL full_stall: got %b want 1", bus.cpu_stall); end
        total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL full_not_ready_ceb: got %b want 1", bus.mem_ceb); end
        tick();
        bus.mem_ready = 1'b1;
        settle();
        total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL full_freed_slot_stall: got %b want 1", bus.cpu_stall); end
        total++; if (bus.mem_ceb !== 1'b0 || bus.mem_web !== 1'b0) begin bad++; $display("FAIL full_drain1: got ceb=%b web=%b want 0 0", bus.mem_ceb, bus.mem_web); end
        total++; if (bus.mem_a !== 14'h001) begin bad++; $display("FAIL full_drain1_a: got %h want 001", bus.mem_a); end
        tick();
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL full_accept5: got %b want 0", bus.cpu_stall); end
        total++; if (bus.mem_a !== 14'h002) begin bad++; $display("FAIL full_drain2_a: got %h want 002", bus.mem_a); end
        tick();
        drive_idle();
        for (int e = 3; e <= 5; e++) begin
            settle();
            total++; if (bus.mem_ceb !== 1'b0 || bus.mem_a !== 14'(e)) begin bad++; $display("FAIL full_drain_seq[%0d]: got ceb=%b a=%h want 0 %h", e, bus.mem_ceb, bus.mem_a, 14'(e)); end
            total++; if (bus.mem_din !== 32'(e) * 32'h0101_0101) begin bad++; $display("FAIL full_drain_din[%0d]: got %h want %h", e, bus.mem_din, 32'(e) * 32'h0101_0101); end
            tick();
        end
        settle();
        total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL full_empty_ceb: got %b want 1", bus.mem_ceb); end
        tick();
    endtask

    task automatic test_forward();
        bus.mem_ready = 1'b0;
        drive_store(14'h020, 32'h0000_00AA, 32'hFFFF_FF00);
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL fwd_store_stall: got %b want 0", bus.cpu_stall); end
        tick();
        drive_load(14'h020);
        bus.mem_dout = 32'h1122_3344;
        settle();
        total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL fwd_load_not_ready_stall: got %b want 1", bus.cpu_stall); end
        tick();
        bus.mem_ready = 1'b1;
        settle();
        total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL fwd_no_rvalid: got %b want 0", bus.cpu_rvalid); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL fwd_load_stall: got %b want 0", bus.cpu_stall); end
        total++; if (bus.mem_ceb !== 1'b0 || bus.mem_web !== 1'b1 || bus.mem_a !== 14'h020) begin bad++; $display("FAIL fwd_load_issue: got ceb=%b web=%b a=%h want 0 1 020", bus.mem_ceb, bus.mem_web, bus.mem_a); end
        tick();
        drive_idle();
        settle();
        total++; if (bus.cpu_rvalid !== 1'b1) begin bad++; $display("FAIL fwd_rvalid: got %b want 1", bus.cpu_rvalid); end
        total++; if (bus.cpu_dout !== 32'h1122_33AA) begin bad++; $display("FAIL fwd_dout: got %h want 112233aa", bus.cpu_dout); end
        total++; if (bus.mem_web !== 1'b0 || bus.mem_bweb !== 32'hFFFF_FF00) begin bad++; $display("FAIL fwd_drain: got web=%b bweb=%h want 0 ffffff00", bus.mem_web, bus.mem_bweb); end
        tick();
        settle();
        total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL fwd_rvalid_drop: got %b want 0", bus.cpu_rvalid); end
        tick();
    endtask

    task automatic test_merge();
        int drains;
        int exp_drains;
        // Two stores that write different bytes of the same word
        bus.mem_ready = 1'b0;
        drive_store(14'h030, 32'h0000_00FF, 32'hFFFF_FF00);
        tick();
        drive_store(14'h030, 32'h0000_AB00, 32'hFFFF_00FF);
        tick();
        drive_load(14'h030);
        bus.mem_dout  = 32'h0;
        bus.mem_ready = 1'b1;
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL merge_load_stall: got %b want 0", bus.cpu_stall); end
        tick();
        drive_idle();
        settle();
        total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_dout !== 32'h0000_ABFF) begin bad++; $display("FAIL merge_dout: got v=%b %h want 1 0000abff", bus.cpu_rvalid, bus.cpu_dout); end
        drains = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.mem_ceb === 1'b0 && bus.mem_web === 1'b0) drains++;
            tick();
            settle();
        end
`ifdef DM_WB_COALESCE_EN
        exp_drains = 1;
`else
        exp_drains = 2;
`endif
        total++; if (drains !== exp_drains) begin bad++; $display("FAIL merge_drain_count: got %0d want %0d", drains, exp_drains); end
        tick();

        // Overlapping stores: the younger store must win on the bits it wrote
        bus.mem_ready = 1'b0;
        drive_store(14'h040, 32'h1111_1111, 32'h0);
        tick();
        drive_store(14'h040, 32'h2222_2222, 32'h0000_FFFF);
        tick();
        drive_load(14'h040);
        bus.mem_dout  = 32'hFFFF_FFFF;
        bus.mem_ready = 1'b1;
        tick();
        drive_idle();
        settle();
        total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_dout !== 32'h2222_1111) begin bad++; $display("FAIL youngest_wins: got v=%b %h want 1 22221111", bus.cpu_rvalid, bus.cpu_dout); end
        for (int c = 0; c < 4; c++) tick();
        settle();
        total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL youngest_drained: got %b want 1", bus.mem_ceb); end
        tick();
    endtask

    task automatic test_flush();
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_store(14'h050 + 14'(k), 32'h0, 32'h0);
            tick();
        end
        drive_idle();
        bus.flush = 1'b1;
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL flush_noreq_stall: got %b want 0", bus.cpu_stall); end
        tick();
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_dout  = 32'h0;
        drive_load(14'h060);
        for (int k = 0; k < 3; k++) begin
            settle();
            total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL flush_stall[%0d]: got %b want 1", k, bus.cpu_stall); end
            total++; if (bus.mem_ceb !== 1'b0 || bus.mem_web !== 1'b0 || bus.mem_a !== 14'h050 + 14'(k)) begin bad++; $display("FAIL flush_drain[%0d]: got ceb=%b web=%b a=%h", k, bus.mem_ceb, bus.mem_web, bus.mem_a); end
            tick();
        end
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL flush_release: got %b want 0", bus.cpu_stall); end
        total++; if (bus.mem_ceb !== 1'b0 || bus.mem_web !== 1'b1 || bus.mem_a !== 14'h060) begin bad++; $display("FAIL flush_load_issue: got ceb=%b web=%b a=%h want 0 1 060", bus.mem_ceb, bus.mem_web, bus.mem_a); end
        tick();
        bus.flush = 1'b1;
        settle();
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL flush_empty_stall: got %b want 0", bus.cpu_stall); end
        total++; if (bus.cpu_rvalid !== 1'b1) begin bad++; $display("FAIL flush_load_rvalid: got %b want 1", bus.cpu_rvalid); end
        tick();
        bus.flush = 1'b0;
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_store(14'h070 + 14'(k), 32'hCAFE_0000 + 32'(k), 32'h0);
            tick();
        end
        drive_idle();
        bus.mem_ready = 1'b1;
        settle();
        total++; if (bus.mem_ceb !== 1'b0 || bus.mem_a !== 14'h070) begin bad++; $display("FAIL rst_first_drain: got ceb=%b a=%h want 0 070", bus.mem_ceb, bus.mem_a); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++; if (bus.mem_ceb !== 1'b1) begin bad++; $display("FAIL rst_discard[%0d]: got ceb=%b want 1", c, bus.mem_ceb); end
            tick();
        end
        // A load presented in the reset cycle never returns data
        drive_load(14'h080);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle();
        settle();
        total++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_dout !== 32'h0) begin bad++; $display("FAIL rst_load_discard: got v=%b %h want 0 0", bus.cpu_rvalid, bus.cpu_dout); end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_drain();
        test_full();
        test_forward();
        test_merge();
        test_flush();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_write_buffer.md
Name: dm_write_buffer

Overview:
- Posted store buffer between the CPU data-memory port and the DM SRAM.
- Stores retire into a FIFO in one cycle and drain to the SRAM when the port is idle.
- Loads bypass the FIFO to the SRAM; buffered bytes are merged over the SRAM data, youngest store winning.
- Drives the CPU stall line when the FIFO cannot accept a store or the SRAM cannot take an access.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
AW, 14, word address width (matches DM_A)
DW, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU DM access valid this cycle
cpu_web  in  1  0 = store, 1 = load (SRAM WEB polarity)
cpu_bweb  in  DW  per-bit write enable, active low (store only)
cpu_a  in  AW  word address
cpu_din  in  DW  store data
cpu_dout  out  DW  load data
cpu_rvalid  out  1  cpu_dout valid
cpu_stall  out  1  CPU must hold its request this cycle
flush  in  1  fence: drain buffer before further accesses
mem_ceb  out  1  SRAM chip enable, active low
mem_web  out  1  SRAM write enable, active low
mem_bweb  out  DW  SRAM bit write enable, active low
mem_a  out  AW  SRAM address
mem_din  out  DW  SRAM write data
mem_dout  in  DW  SRAM read data, valid one cycle after an accepted read
mem_ready  in  1  SRAM accepts an access this cycle

Behaviour:
- Single clock domain, clk; reset synchronous, active-high on rst.
- Reset values:
  - FIFO empty, head/tail/count = 0.
  - mem_ceb=1, mem_web=1, mem_bweb=all 1s, mem_a=0, mem_din=0.
  - cpu_stall=0, cpu_rvalid=0, cpu_dout=0.
- Reset mid-operation discards buffered stores and any pending load return.
- FIFO entry: {addr, data, wmask}, where wmask = ~cpu_bweb.
- Store: if cpu_req & !cpu_web & count<DEPTH & !flush_pending, the entry is enqueued at tail this cycle and cpu_stall=0.
- A store with count==DEPTH sets cpu_stall=1. A slot freed by a same-cycle drain is not usable until the next cycle.
- One SRAM access per cycle. The access is issued only when mem_ready=1; mem_* outputs are combinational from arbitration.
- Arbitration priority, highest first:
  1. Drain, when count==DEPTH or flush_pending.
  2. CPU load.
  3. Drain, when count>0.
- Load accepted: mem_ceb=0, mem_web=1, mem_a=cpu_a, cpu_stall=0.
  - In the same cycle, the forward mask and data are computed from all valid entries with addr==cpu_a, per bit, youngest entry with wmask bit 1 wins. Both are registered.
  - Next cycle: cpu_rvalid=1, cpu_dout = (fwd_data & fwd_mask) | (mem_dout & ~fwd_mask).
- A load that is not accepted (mem_ready=0, or a higher-priority drain) sets cpu_stall=1. cpu_rvalid=0 otherwise.
- Drain: mem_ceb=0, mem_web=0, mem_a/mem_din from head, mem_bweb=~head.wmask. Head advances and count decrements on the accepting edge.
- Simultaneous store enqueue and drain: count unchanged. Pointers wrap modulo DEPTH.
- A store and a load in the same cycle cannot occur (one CPU port).
- flush:
  - flush=1 sets flush_pending.
  - While flush_pending: cpu_stall=1 for any cpu_req, and drains run back to back whenever mem_ready=1.
  - flush_pending clears the cycle count reaches 0 with flush=0. flush with an empty FIFO produces no stall.
- No outputs are undefined. When idle, mem_ceb=1 and the other mem_* outputs hold their last values.

Optional Feature:
- Macro: DM_WB_COALESCE_EN.
- Defined: a store whose address equals the youngest valid entry's addr, with that entry not being drained this cycle, merges into it:
  - data = (data & ~newmask) | (cpu_din & newmask)
  - wmask |= newmask
  - count unchanged, accepted even when full.
- Undefined: every store allocates a new entry.

Test Plan:
- Reset then idle -> mem_ceb=1, cpu_stall=0, cpu_rvalid=0, cpu_dout=0.
- Store A=0x010 D=0xDEADBEEF bweb=0, mem_ready=1, no loads -> next cycle mem_web=0, mem_a=0x010, mem_din=0xDEADBEEF, mem_bweb=0; count returns to 0.
- mem_ready=0, 5 stores to A=0x001..0x005 (DEPTH=4) -> 5th store sees cpu_stall=1; raise mem_ready -> 0x001 drains first, 5th accepted the cycle after.
- mem_ready=0, store A=0x020 D=0x000000AA bweb=0xFFFFFF00, then mem_ready=1 and load A=0x020 with SRAM holding 0x11223344 -> cpu_dout=0x112233AA, cpu_rvalid=1.
- Two stores to A=0x030 (0x000000FF mask byte0, then 0x0000AB00 mask byte1), held, then load with SRAM=0 -> cpu_dout=0x0000ABFF. With DM_WB_COALESCE_EN, count=1 after both stores.
- 3 stores buffered with mem_ready=0, pulse flush, then mem_ready=1 -> cpu_stall=1 for 3 cycles while 3 drains issue; stall drops when count=0. rst asserted mid-drain -> count=0, mem_ceb=1 next cycle.
